// File: rtl/pipeline_scoreboard.sv
// -----------------------------------------------------------------------------
// pipeline_scoreboard
//   Issue-stage scoreboard for an in-order pipeline. It tracks in-flight
//   register writers across NUM_STAGES post-issue stages. For the instruction
//   in ID it decides whether that instruction must stall on a load-use hazard.
//   It also pre-computes, and registers, the EX forwarding select for each
//   source operand, so EX needs no address comparators of its own.
//
// Parameters
//   REG_ADDR_W      register address width
//   NUM_STAGES      post-issue stages holding writers (1 = EX ... NUM_STAGES =
//                   last stage before the register-file write), legal 2..8
//   LOAD_FWD_STAGE  lowest stage a load result can be forwarded from,
//                   legal 2..NUM_STAGES
//   FWD_SEL_W       forward-select width
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   issue_valid_i       ID holds an instruction requesting issue
//   issue_rs_i/_used_i  source A address / source A is read
//   issue_rt_i/_used_i  source B address / source B is read
//   issue_dest_i        destination address
//   issue_regwrite_i    instruction writes a register
//   issue_load_i        instruction is a load
//   flush_i             kill the ID instruction (taken branch)
//   stall_o             hold PC and IF/ID, bubble into ID/EX (combinational)
//   issue_fire_o        instruction accepted this cycle (combinational)
//   fwd_rs_o / fwd_rt_o EX select, 0 = register file, k = stage k (registered)
//   busy_o              busy_o[k-1] is set when stage k holds a valid writer
//
// Build option
//   SB_NO_FWD_EN  disables forwarding. Any consumer of an in-flight writer
//                 stalls until that writer reaches stage NUM_STAGES, where
//                 the write-through register file supplies the value.
// -----------------------------------------------------------------------------
module pipeline_scoreboard #(
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned LOAD_FWD_STAGE = 3,
    parameter int unsigned FWD_SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_rs_i,
    input  logic [REG_ADDR_W-1:0] issue_rt_i,
    input  logic                  issue_rs_used_i,
    input  logic                  issue_rt_used_i,
    input  logic [REG_ADDR_W-1:0] issue_dest_i,
    input  logic                  issue_regwrite_i,
    input  logic                  issue_load_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  issue_fire_o,
    output logic [FWD_SEL_W-1:0]  fwd_rs_o,
    output logic [FWD_SEL_W-1:0]  fwd_rt_o,
    output logic [NUM_STAGES-1:0] busy_o
);

    localparam int NS  = int'(NUM_STAGES);
    localparam int LFS = int'(LOAD_FWD_STAGE);

    // Elaboration-time legality checks on the configuration.
    if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_num_stages
        $error("pipeline_scoreboard: NUM_STAGES must be 2..8");
    end
    if (LOAD_FWD_STAGE < 2 || LOAD_FWD_STAGE > NUM_STAGES) begin : g_bad_load_fwd
        $error("pipeline_scoreboard: LOAD_FWD_STAGE must be 2..NUM_STAGES");
    end

    // Writer shift register. Array index i holds pipeline stage i+1.
    logic [NUM_STAGES-1:0] r_v;
    logic [REG_ADDR_W-1:0] r_dest [NUM_STAGES];
    logic [NUM_STAGES-1:0] r_load;
    logic [FWD_SEL_W-1:0]  r_fwd_rs;
    logic [FWD_SEL_W-1:0]  r_fwd_rt;

    // Youngest matching stage per source, 1-based; 0 means no match.
    int                    w_rs_j;
    int                    w_rt_j;
    logic                  w_rs_ld;
    logic                  w_rt_ld;
    logic                  w_rs_haz;
    logic                  w_rt_haz;
    logic [FWD_SEL_W-1:0]  w_rs_sel;
    logic [FWD_SEL_W-1:0]  w_rt_sel;
    logic                  w_req;
    logic                  w_ins_v;

    // Find the youngest in-flight writer of each source. The loop scans from
    // old to young, so a younger match overwrites an older one. Only entries
    // already in flight take part, so an instruction that reads its own
    // destination register never matches itself.
    always_comb begin : src_match
        w_rs_j  = 0;
        w_rt_j  = 0;
        w_rs_ld = 1'b0;
        w_rt_ld = 1'b0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (issue_rs_used_i && issue_rs_i != '0 &&
                r_v[i] && r_dest[i] == issue_rs_i) begin
                w_rs_j  = i + 1;
                w_rs_ld = r_load[i];
            end
            if (issue_rt_used_i && issue_rt_i != '0 &&
                r_v[i] && r_dest[i] == issue_rt_i) begin
                w_rt_j  = i + 1;
                w_rt_ld = r_load[i];
            end
        end
    end

`ifdef SB_NO_FWD_EN
    // A producer can only be read once it sits in the last stage, where the
    // register file write is visible to the ID read in the same cycle.
    logic w_unused_ld;
    assign w_unused_ld = w_rs_ld | w_rt_ld;

    always_comb begin : hazard_nofwd
        w_rs_haz = (w_rs_j != 0) && (w_rs_j < NS);
        w_rt_haz = (w_rt_j != 0) && (w_rt_j < NS);
        w_rs_sel = '0;
        w_rt_sel = '0;
    end
`else
    // By the time the consumer reaches EX, the producer found at stage j has
    // moved on to stage j+1. A producer already in the last stage is covered
    // by the write-through register file, so it needs no forward. A load
    // result does not exist before LOAD_FWD_STAGE, so the consumer waits.
    always_comb begin : hazard_fwd
        w_rs_haz = w_rs_ld && (w_rs_j != 0) && (w_rs_j + 1 < LFS);
        w_rt_haz = w_rt_ld && (w_rt_j != 0) && (w_rt_j + 1 < LFS);
        w_rs_sel = '0;
        w_rt_sel = '0;
        if (w_rs_j != 0 && w_rs_j + 1 <= NS) begin
            w_rs_sel = FWD_SEL_W'(w_rs_j + 1);
        end
        if (w_rt_j != 0 && w_rt_j + 1 <= NS) begin
            w_rt_sel = FWD_SEL_W'(w_rt_j + 1);
        end
    end
`endif

    // Issue decision. A flush kills the ID instruction, so it also drops any
    // stall that instruction would have caused.
    assign w_req        = issue_valid_i & ~flush_i;
    assign stall_o      = w_req & (w_rs_haz | w_rt_haz);
    assign issue_fire_o = w_req & ~(w_rs_haz | w_rt_haz);
    assign w_ins_v      = issue_fire_o & issue_regwrite_i & (issue_dest_i != '0);

    // Advance the writer pipeline and register the EX forward selects.
    always_ff @(posedge clk) begin : seq
        if (rst) begin
            r_v      <= '0;
            r_load   <= '0;
            r_fwd_rs <= '0;
            r_fwd_rt <= '0;
            for (int k = 0; k < NS; k++) begin
                r_dest[k] <= '0;
            end
        end else begin
            for (int k = NS - 1; k >= 1; k--) begin
                r_v[k]    <= r_v[k-1];
                r_dest[k] <= r_dest[k-1];
                r_load[k] <= r_load[k-1];
            end
            r_v[0]    <= w_ins_v;
            r_dest[0] <= issue_dest_i;
            r_load[0] <= issue_load_i & w_ins_v;
            r_fwd_rs  <= issue_fire_o ? w_rs_sel : '0;
            r_fwd_rt  <= issue_fire_o ? w_rt_sel : '0;
        end
    end

    assign fwd_rs_o = r_fwd_rs;
    assign fwd_rt_o = r_fwd_rt;
    assign busy_o   = r_v;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_pipeline_scoreboard
//   Directed bench for pipeline_scoreboard with its default parameters
//   (REG_ADDR_W=5, NUM_STAGES=3, LOAD_FWD_STAGE=3). Inputs change on the
//   falling edge. Combinational outputs are checked just after that edge.
//   Registered outputs are checked on the falling edge after the rising
//   edge that loaded them.
// -----------------------------------------------------------------------------
module tb_pipeline_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid_i;
    logic [4:0] issue_rs_i;
    logic [4:0] issue_rt_i;
    logic       issue_rs_used_i;
    logic       issue_rt_used_i;
    logic [4:0] issue_dest_i;
    logic       issue_regwrite_i;
    logic       issue_load_i;
    logic       flush_i;
    logic       stall_o;
    logic       issue_fire_o;
    logic [1:0] fwd_rs_o;
    logic [1:0] fwd_rt_o;
    logic [2:0] busy_o;

    int n_total = 0;
    int n_bad   = 0;

    pipeline_scoreboard dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid_i    (issue_valid_i),
        .issue_rs_i       (issue_rs_i),
        .issue_rt_i       (issue_rt_i),
        .issue_rs_used_i  (issue_rs_used_i),
        .issue_rt_used_i  (issue_rt_used_i),
        .issue_dest_i     (issue_dest_i),
        .issue_regwrite_i (issue_regwrite_i),
        .issue_load_i     (issue_load_i),
        .flush_i          (flush_i),
        .stall_o          (stall_o),
        .issue_fire_o     (issue_fire_o),
        .fwd_rs_o         (fwd_rs_o),
        .fwd_rt_o         (fwd_rt_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Move to the next falling edge, passing through one rising edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present an instruction in ID: valid, rs, rs_used, rt, rt_used, dest, regwrite, load.
    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu,
                         input logic [4:0] dest, input logic rw, input logic ld);
        issue_valid_i    = v;
        issue_rs_i       = rs;
        issue_rs_used_i  = rsu;
        issue_rt_i       = rt;
        issue_rt_used_i  = rtu;
        issue_dest_i     = dest;
        issue_regwrite_i = rw;
        issue_load_i     = ld;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst     = 1'b1;
        flush_i = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_busy",  busy_o, 0);
        chk("rst_fwdrs", fwd_rs_o, 0);
        chk("rst_fwdrt", fwd_rt_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_fire",  issue_fire_o, 0);

`ifdef SB_NO_FWD_EN
        // add r3, then a consumer of r3 stalls two cycles and fires with no forward
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);
        chk("nf_stall1", stall_o, 1);
        step();
        #1;
        chk("nf_stall2", stall_o, 1);
        chk("nf_busy",   busy_o, 3'b010);
        step();
        #1;
        chk("nf_stall3", stall_o, 0);
        chk("nf_fire",   issue_fire_o, 1);
        step();
        chk("nf_fwdrs",  fwd_rs_o, 0);
        chk("nf_fwdrt",  fwd_rt_o, 0);
        idle(3);
`else
        // add r3 ; add r4,r3,r1 -> forward from stage 2
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        chk("t1_fire0", issue_fire_o, 1);
        step();
        drive(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);
        chk("t1_stall", stall_o, 0);
        chk("t1_fire1", issue_fire_o, 1);
        step();
        chk("t1_fwdrs", fwd_rs_o, 2);
        chk("t1_fwdrt", fwd_rt_o, 0);
        chk("t1_busy",  busy_o, 3'b011);
        idle(3);
        chk("t1_drain", busy_o, 0);

        // lw r5 ; add r6,r5,r5 -> one stall, then forward both from stage 3
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        chk("t2_stall", stall_o, 1);
        chk("t2_nofire", issue_fire_o, 0);
        step();
        #1;
        chk("t2_bubble", busy_o, 3'b010);
        chk("t2_stall2", stall_o, 0);
        chk("t2_fire",   issue_fire_o, 1);
        step();
        chk("t2_fwdrs",  fwd_rs_o, 3);
        chk("t2_fwdrt",  fwd_rt_o, 3);
        chk("t2_busy",   busy_o, 3'b101);
        idle(3);

        // producer r7, one unrelated, consumer -> stage 3
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        chk("t3_stall", stall_o, 0);
        step();
        chk("t3_fwd3", fwd_rs_o, 3);
        idle(3);

        // producer r7 as a load, two unrelated, consumer on rt -> register file
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd12, 1'b1, 1'b0);
        chk("t3b_stall", stall_o, 0);
        chk("t3b_fire",  issue_fire_o, 1);
        step();
        chk("t3b_fwdrt", fwd_rt_o, 0);
        idle(3);

        // two writers of r2; youngest wins
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0);
        step();
        chk("t4_young_rs", fwd_rs_o, 2);
        chk("t4_young_rt", fwd_rt_o, 2);
        idle(3);

        // load writing r0 is never tracked; reading r0 never stalls or forwards
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        step();
        chk("t4_r0_busy", busy_o, 0);
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd14, 1'b1, 1'b0);
        chk("t4_r0_stall", stall_o, 0);
        step();
        chk("t4_r0_fwd", fwd_rs_o, 0);
        idle(3);

        // load reading its own destination is not a hazard
        drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        chk("t4_self_stall", stall_o, 0);
        chk("t4_self_fire",  issue_fire_o, 1);
        idle(3);

        // load-use with flush -> no stall, no fire, bubble
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        flush_i = 1'b1;
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        chk("t5_flush_stall", stall_o, 0);
        chk("t5_flush_fire",  issue_fire_o, 0);
        step();
        flush_i = 1'b0;
        chk("t5_flush_busy", busy_o, 3'b010);
        chk("t5_flush_fwd",  fwd_rs_o, 0);
        idle(3);

        // fill the pipe, reset, then a consumer sees no hazard
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
        step();
        chk("t5_full", busy_o, 3'b111);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_rst_busy", busy_o, 0);
        drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
        chk("t5_rst_stall", stall_o, 0);
        step();
        chk("t5_rst_fwd", fwd_rs_o, 0);
        idle(3);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
